// File: rtl/merlin_mtimer.sv
// merlin_mtimer: RISC-V machine timer on the Merlin data port.
// 64-bit mtime with a programmable prescaler, 64-bit mtimecmp, a ctrl.en bit,
// a single-slot read response, and a registered level timer interrupt.
module merlin_mtimer #(
  parameter int unsigned C_PRESCALE = 1,
  parameter int unsigned C_ADDR_W   = 5
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  output logic        treqready_o,
  input  logic        treqvalid_i,
  input  logic        treqdvalid_i,
  input  logic [31:0] treqaddr_i,
  input  logic [31:0] treqdata_i,
  input  logic        trspready_i,
  output logic        trspvalid_o,
  output logic [31:0] trspdata_o,
  output logic        irq_timer_o
);

  localparam logic [15:0] PRESC_LAST = 16'(C_PRESCALE - 1);

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        en_q;
  logic [15:0] presc_q;

  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] word_idx;
  logic        sel_mtime_lo;
  logic        sel_mtime_hi;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_ctrl;
  logic        tick;
  logic [15:0] presc_nxt;
  logic [63:0] mtime_nxt;
  logic [31:0] rdata;
  logic        unused_addr;

  // Address bits outside the decoded window are intentionally ignored.
  assign unused_addr = ^{treqaddr_i[31:C_ADDR_W], treqaddr_i[1:0]};

  // The response slot frees up in the same cycle it drains.
  assign treqready_o = ~trspvalid_o | trspready_i;
  assign accept      = treqvalid_i & treqready_o;
  assign wr_en       = accept & treqdvalid_i;
  assign rd_en       = accept & ~treqdvalid_i;

  assign word_idx     = 32'(treqaddr_i[C_ADDR_W-1:2]);
  assign sel_mtime_lo = (word_idx == 32'd0);
  assign sel_mtime_hi = (word_idx == 32'd1);
  assign sel_cmp_lo   = (word_idx == 32'd2);
  assign sel_cmp_hi   = (word_idx == 32'd3);
  assign sel_ctrl     = (word_idx == 32'd4);

  assign tick = en_q & (presc_q == PRESC_LAST);

  // Prescaler wraps at C_PRESCALE-1 while enabled and is parked at 0 otherwise.
  always_comb begin
    presc_nxt = 16'd0;
    if (en_q && (presc_q != PRESC_LAST)) begin
      presc_nxt = presc_q + 16'd1;
    end
  end

  // A write to either mtime half wins over the tick; the other half holds.
  always_comb begin
    mtime_nxt = mtime_q + 64'(tick);
    if (wr_en && sel_mtime_lo) begin
      mtime_nxt = {mtime_q[63:32], treqdata_i};
    end else if (wr_en && sel_mtime_hi) begin
      mtime_nxt = {treqdata_i, mtime_q[31:0]};
    end
  end

  // Read mux over current (pre-edge) register state.
  always_comb begin
    rdata = 32'd0;
    if (sel_mtime_lo) begin
      rdata = mtime_q[31:0];
    end else if (sel_mtime_hi) begin
      rdata = mtime_q[63:32];
    end else if (sel_cmp_lo) begin
      rdata = mtimecmp_q[31:0];
    end else if (sel_cmp_hi) begin
      rdata = mtimecmp_q[63:32];
    end else if (sel_ctrl) begin
      rdata = {31'd0, en_q};
    end
  end

  // Timer state, register writes and the registered compare.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q        <= 1'b0;
      presc_q     <= 16'd0;
      irq_timer_o <= 1'b0;
    end else if (clk_en_i) begin
      mtime_q <= mtime_nxt;
      presc_q <= presc_nxt;
      if (wr_en && sel_cmp_lo) begin
        mtimecmp_q[31:0] <= treqdata_i;
      end
      if (wr_en && sel_cmp_hi) begin
        mtimecmp_q[63:32] <= treqdata_i;
      end
      if (wr_en && sel_ctrl) begin
        en_q <= treqdata_i[0];
      end
      // Compare uses registered values, so irq follows mtime by one cycle.
      irq_timer_o <= (mtime_q >= mtimecmp_q);
    end
  end

  // Single read-response slot held until the requester takes it.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      trspvalid_o <= 1'b0;
      trspdata_o  <= 32'd0;
    end else if (clk_en_i) begin
      if (rd_en) begin
        trspvalid_o <= 1'b1;
        trspdata_o  <= rdata;
      end else if (trspready_i) begin
        trspvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merlin_mtimer.sv
// Directed bench for merlin_mtimer: u0 uses C_PRESCALE=4, u1 uses C_PRESCALE=1.
module tb_merlin_mtimer;

  logic        clk = 1'b0;
  logic        resetb    [2];
  logic        clk_en    [2];
  logic        treqready [2];
  logic        treqvalid [2];
  logic        treqdvalid[2];
  logic [31:0] treqaddr  [2];
  logic [31:0] treqdata  [2];
  logic        trspready [2];
  logic        trspvalid [2];
  logic [31:0] trspdata  [2];
  logic        irq       [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  merlin_mtimer #(.C_PRESCALE(4), .C_ADDR_W(5)) u0 (
    .clk_i(clk), .resetb_i(resetb[0]), .clk_en_i(clk_en[0]),
    .treqready_o(treqready[0]), .treqvalid_i(treqvalid[0]), .treqdvalid_i(treqdvalid[0]),
    .treqaddr_i(treqaddr[0]), .treqdata_i(treqdata[0]), .trspready_i(trspready[0]),
    .trspvalid_o(trspvalid[0]), .trspdata_o(trspdata[0]), .irq_timer_o(irq[0])
  );

  merlin_mtimer #(.C_PRESCALE(1), .C_ADDR_W(5)) u1 (
    .clk_i(clk), .resetb_i(resetb[1]), .clk_en_i(clk_en[1]),
    .treqready_o(treqready[1]), .treqvalid_i(treqvalid[1]), .treqdvalid_i(treqdvalid[1]),
    .treqaddr_i(treqaddr[1]), .treqdata_i(treqdata[1]), .trspready_i(trspready[1]),
    .trspvalid_o(trspvalid[1]), .trspdata_o(trspdata[1]), .irq_timer_o(irq[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; write accepted at the next posedge.
  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
    treqvalid[d] = 1'b1; treqdvalid[d] = 1'b1; treqaddr[d] = a; treqdata[d] = v;
    @(posedge clk); @(negedge clk);
    treqvalid[d] = 1'b0; treqdvalid[d] = 1'b0;
  endtask

  // Called at a negedge; read accepted at the next posedge, response checked after it.
  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] e, input string tag);
    treqvalid[d] = 1'b1; treqdvalid[d] = 1'b0; treqaddr[d] = a;
    @(posedge clk); @(negedge clk);
    treqvalid[d] = 1'b0;
    chk({tag, "_vld"}, 64'(trspvalid[d]), 64'd1);
    chk(tag, 64'(trspdata[d]), 64'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      resetb[d] = 1'b0; clk_en[d] = 1'b1; treqvalid[d] = 1'b0; treqdvalid[d] = 1'b0;
      treqaddr[d] = 32'd0; treqdata[d] = 32'd0; trspready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetb[0] = 1'b1; resetb[1] = 1'b1;

    // Reset state
    chk("rst_rspvalid", 64'(trspvalid[0]), 64'd0);
    chk("rst_rspdata", 64'(trspdata[0]), 64'd0);
    chk("rst_reqready", 64'(treqready[0]), 64'd1);
    chk("rst_irq", 64'(irq[0]), 64'd0);

    // Register reads after reset
    rd(0, 32'h00, 32'h0000_0000, "rst_mtime_lo");
    rd(0, 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(0, 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(0, 32'h10, 32'h0000_0000, "rst_ctrl");
    rd(0, 32'h18, 32'h0000_0000, "rst_reserved");
    chk("rst_irq_after_reads", 64'(irq[0]), 64'd0);

    // Prescaled count: enable at edge N, disable at N+40 -> 10 ticks
    wr(0, 32'h10, 32'd1);
    repeat (39) @(negedge clk);
    wr(0, 32'h10, 32'd0);
    rd(0, 32'h00, 32'd10, "presc_count");
    repeat (20) @(negedge clk);
    rd(0, 32'h00, 32'd10, "presc_hold");
    rd(0, 32'h04, 32'd0, "presc_hi");

    // Reserved writes ignored, ctrl upper bits read 0
    wr(0, 32'h14, 32'h1234_5678);
    rd(0, 32'h14, 32'd0, "reserved_wr");
    wr(0, 32'h10, 32'hFFFF_FFFE);
    rd(0, 32'h10, 32'd0, "ctrl_upper");

    // Carry: one tick from {0, FFFFFFFF}
    wr(1, 32'h00, 32'hFFFF_FFFF);
    wr(1, 32'h04, 32'h0000_0000);
    wr(1, 32'h10, 32'd1);
    wr(1, 32'h10, 32'd0);
    rd(1, 32'h00, 32'd0, "carry_lo");
    rd(1, 32'h04, 32'd1, "carry_hi");

    // Wrap: all-ones equals reset mtimecmp, irq follows one cycle later
    wr(1, 32'h04, 32'hFFFF_FFFF);
    wr(1, 32'h00, 32'hFFFF_FFFF);
    wr(1, 32'h10, 32'd1);
    chk("wrap_irq_equal", 64'(irq[1]), 64'd1);
    wr(1, 32'h10, 32'd0);
    rd(1, 32'h00, 32'd0, "wrap_lo");
    chk("wrap_irq_clear", 64'(irq[1]), 64'd0);
    rd(1, 32'h04, 32'd0, "wrap_hi");

    // Interrupt at mtime == 20
    wr(1, 32'h08, 32'd20);
    wr(1, 32'h0C, 32'd0);
    chk("irq_idle", 64'(irq[1]), 64'd0);
    wr(1, 32'h10, 32'd1);
    repeat (20) @(negedge clk);
    chk("irq_not_yet", 64'(irq[1]), 64'd0);
    @(negedge clk);
    chk("irq_rise", 64'(irq[1]), 64'd1);
    wr(1, 32'h0C, 32'd1);
    chk("irq_cmp_wr_edge", 64'(irq[1]), 64'd1);
    @(negedge clk);
    chk("irq_drop", 64'(irq[1]), 64'd0);
    wr(1, 32'h10, 32'd0);

    // Backpressure
    trspready[1] = 1'b0;
    treqvalid[1] = 1'b1; treqdvalid[1] = 1'b0; treqaddr[1] = 32'h10;
    @(posedge clk); @(negedge clk);
    chk("bp_first_vld", 64'(trspvalid[1]), 64'd1);
    chk("bp_first_data", 64'(trspdata[1]), 64'd0);
    treqaddr[1] = 32'h08;
    chk("bp_stall_ready", 64'(treqready[1]), 64'd0);
    @(negedge clk);
    chk("bp_hold_vld", 64'(trspvalid[1]), 64'd1);
    chk("bp_hold_data", 64'(trspdata[1]), 64'd0);
    chk("bp_hold_ready", 64'(treqready[1]), 64'd0);
    trspready[1] = 1'b1;
    #1;
    chk("bp_ready_comb", 64'(treqready[1]), 64'd1);
    @(posedge clk); @(negedge clk);
    treqvalid[1] = 1'b0;
    chk("bp_second_vld", 64'(trspvalid[1]), 64'd1);
    chk("bp_second_data", 64'(trspdata[1]), 64'd20);
    @(negedge clk);
    chk("bp_drained", 64'(trspvalid[1]), 64'd0);

    // Write/tick collision: lo write on a tick cycle, no carry into hi
    wr(1, 32'h04, 32'd7);
    wr(1, 32'h00, 32'hFFFF_FFFF);
    wr(1, 32'h10, 32'd1);
    wr(1, 32'h00, 32'd5);
    rd(1, 32'h00, 32'd5, "coll_lo");
    rd(1, 32'h04, 32'd7, "coll_hi");
    wr(1, 32'h10, 32'd0);

    // clk_en low freezes the pending response
    trspready[1] = 1'b0;
    treqvalid[1] = 1'b1; treqdvalid[1] = 1'b0; treqaddr[1] = 32'h08;
    @(posedge clk); @(negedge clk);
    treqvalid[1] = 1'b0;
    clk_en[1] = 1'b0; trspready[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("clken_freeze_vld", 64'(trspvalid[1]), 64'd1);
    clk_en[1] = 1'b1;
    @(negedge clk);
    chk("clken_resume_drain", 64'(trspvalid[1]), 64'd0);

    // Reset with a response pending
    trspready[1] = 1'b0;
    treqvalid[1] = 1'b1; treqdvalid[1] = 1'b0; treqaddr[1] = 32'h08;
    @(posedge clk); @(negedge clk);
    treqvalid[1] = 1'b0;
    chk("rst_mid_pending", 64'(trspvalid[1]), 64'd1);
    resetb[1] = 1'b0;
    @(negedge clk);
    resetb[1] = 1'b1;
    chk("rst_mid_vld", 64'(trspvalid[1]), 64'd0);
    chk("rst_mid_data", 64'(trspdata[1]), 64'd0);
    chk("rst_mid_ready", 64'(treqready[1]), 64'd1);
    trspready[1] = 1'b1;
    rd(1, 32'h08, 32'hFFFF_FFFF, "rst_mid_cmp");
    rd(1, 32'h00, 32'd0, "rst_mid_mtime");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
